// File: rtl/wr_burst_sched.sv
// Write-burst scheduler: tracks fifo_word occupancy, requests an SDRAM burst when the
// fifo fills (or on flush), then streams exactly burst_len words out behind the grant.
module wr_burst_sched #(
  parameter int ADDR_W = 24,
  parameter int BURST  = 4
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              fifo_write_enable,
  input  logic              fifo_full,
  input  logic              fifo_empty,
  input  logic [31:0]       fifo_rdata,
  output logic              fifo_read_enable,
  input  logic              flush,
  input  logic              cfg_load,
  input  logic [ADDR_W-1:0] cfg_addr,
  output logic              burst_req,
  output logic [ADDR_W-1:0] burst_addr,
  output logic [2:0]        burst_len,
  input  logic              burst_grant,
  output logic [31:0]       sdram_wdata,
  output logic              sdram_wvalid,
  output logic              burst_done,
  output logic              underrun
);

  localparam int CW = $clog2(BURST + 1);

  typedef enum logic [2:0] {IDLE, REQ, POP, DRAIN, DONE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] occ;
  logic [2:0]    beat;
  logic          pop_slot, start, last_pop, wr_inc;
  logic [1:0]    vld_pipe;

  assign wr_inc   = fifo_write_enable && !fifo_full;
  assign start    = (occ == CW'(BURST)) || (flush && (occ != '0));
  assign last_pop = (beat == burst_len - 3'd1);

  // state register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  // next-state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)       state_nxt = REQ;
      REQ:     if (burst_grant) state_nxt = POP;
      POP:     if (last_pop)    state_nxt = DRAIN;
      DRAIN:                    state_nxt = DONE;
      DONE:                     state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  // outputs; a pop slot with an empty fifo is suppressed but still counts as a beat
  always_comb begin
    pop_slot         = (state == POP);
    fifo_read_enable = pop_slot && !fifo_empty;
    burst_req        = (state == REQ);
    burst_done       = (state == DONE);
  end

  assign vld_pipe[0]  = fifo_read_enable;
  assign sdram_wvalid = vld_pipe[1];
  assign sdram_wdata  = sdram_wvalid ? fifo_rdata : 32'd0;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      occ         <= '0;
      beat        <= '0;
      burst_len   <= '0;
      burst_addr  <= '0;
      underrun    <= 1'b0;
      vld_pipe[1] <= 1'b0;
    end else begin
      vld_pipe[1] <= vld_pipe[0];
      case ({wr_inc, pop_slot})
        2'b10:   if (occ != CW'(BURST)) occ <= occ + CW'(1);
        2'b01:   if (occ != '0)         occ <= occ - CW'(1);
        default: ;
      endcase
      beat <= pop_slot ? beat + 3'd1 : 3'd0;
      if (state == IDLE && start) burst_len <= 3'(occ);
      // cfg_load wins over the same-cycle start because burst_addr is only read after REQ
      if (state == IDLE && cfg_load) burst_addr <= cfg_addr;
      else if (state == DONE)        burst_addr <= burst_addr + ADDR_W'(burst_len);
      if (pop_slot && fifo_empty) underrun <= 1'b1;
    end
  end

endmodule
